reservation_station_ooo: RTL

Parametrised, tag-based reservation station for one functional-unit class (integer ALU, mul/div, or load/store by instance). It buffers up to DEPTH dispatched instructions and wakes both source operands independently from the CDB, matching on ROB-index tags. It issues the oldest fully-ready entry through a valid/ready handshake to its functional unit. It sits between dispatch and the FU; the ROB supplies tags and the CDB returns results.

---
 rtl/reservation_station_ooo.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/reservation_station_ooo.sv
// -----------------------------------------------------------------------------
// reservation_station_ooo
//
// Tag-based reservation station for one functional-unit class. It holds up to
// DEPTH dispatched instructions. Each source operand wakes independently when
// the CDB broadcasts the producing ROB tag. Each cycle the oldest entry with
// both operands ready is offered to the functional unit through a valid/ready
// handshake.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   flush                discards every entry at the next edge
//   disp_*               dispatch request, ROB tag, payload and source operands
//                        (disp_ready = at least one free entry)
//   cdb_*                result broadcast (tag + value) used for wakeup
//   iss_*                issue candidate towards the FU (iss_ready = accept)
//   free_count           number of free entries (registered)
//
// Ages form a dense permutation 0..valid_count-1, where 0 is the oldest entry.
// A new entry takes the age equal to the number of entries that remain after
// any issue in the same cycle. An issue decrements every younger age by one.
// -----------------------------------------------------------------------------
module reservation_station_ooo #(
    parameter int DEPTH     = 8,
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [PAYLOAD_W-1:0]       disp_payload,
    input  logic [ROB_IDX_W-1:0]       disp_rob_idx,
    input  logic                       disp_rs1_ready,
    input  logic [ROB_IDX_W-1:0]       disp_rs1_tag,
    input  logic [DATA_W-1:0]          disp_rs1_data,
    input  logic                       disp_rs2_ready,
    input  logic [ROB_IDX_W-1:0]       disp_rs2_tag,
    input  logic [DATA_W-1:0]          disp_rs2_data,
    input  logic                       cdb_valid,
    input  logic [ROB_IDX_W-1:0]       cdb_rob_idx,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [PAYLOAD_W-1:0]       iss_payload,
    output logic [ROB_IDX_W-1:0]       iss_rob_idx,
    output logic [DATA_W-1:0]          iss_rs1_data,
    output logic [DATA_W-1:0]          iss_rs2_data,
    output logic [$clog2(DEPTH+1)-1:0] free_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry storage
    logic [DEPTH-1:0]     valid_r;
    logic [PAYLOAD_W-1:0] payload_r  [DEPTH];
    logic [ROB_IDX_W-1:0] rob_idx_r  [DEPTH];
    logic [DEPTH-1:0]     rs1_rdy_r;
    logic [ROB_IDX_W-1:0] rs1_tag_r  [DEPTH];
    logic [DATA_W-1:0]    rs1_data_r [DEPTH];
    logic [DEPTH-1:0]     rs2_rdy_r;
    logic [ROB_IDX_W-1:0] rs2_tag_r  [DEPTH];
    logic [DATA_W-1:0]    rs2_data_r [DEPTH];
    logic [IDX_W-1:0]     age_r      [DEPTH];
    logic [CNT_W-1:0]     free_count_r;

    // Select / allocation / control signals
    logic                 sel_found_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic [IDX_W-1:0]     sel_age_s;
    logic                 free_found_s;
    logic [IDX_W-1:0]     free_idx_s;
    logic                 issue_fire_s;
    logic                 disp_fire_s;
    logic [CNT_W-1:0]     valid_cnt_s;
    logic [CNT_W-1:0]     keep_cnt_s;
    logic [CNT_W-1:0]     free_next_s;
    logic [IDX_W-1:0]     disp_age_s;
    logic                 disp_rs1_hit_s;
    logic                 disp_rs2_hit_s;
    logic [DATA_W-1:0]    disp_rs1_val_s;
    logic [DATA_W-1:0]    disp_rs2_val_s;

    // Population count of the valid vector
    function automatic logic [CNT_W-1:0] count_ones(input logic [DEPTH-1:0] vec);
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            acc = acc + CNT_W'(vec[i]);
        end
        return acc;
    endfunction

    // Oldest-ready select: the ready entry with the smallest age wins
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        sel_age_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && rs1_rdy_r[i] && rs2_rdy_r[i] &&
                (!sel_found_s || (age_r[i] < sel_age_s))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IDX_W'(i);
                sel_age_s   = age_r[i];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Allocation: lowest-index free entry
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_r[i] && !free_found_s) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Dispatch-time CDB bypass, so a producer broadcasting this cycle is not missed
    always_comb begin
        disp_rs1_hit_s = !disp_rs1_ready && cdb_valid && (cdb_rob_idx == disp_rs1_tag);
        disp_rs2_hit_s = !disp_rs2_ready && cdb_valid && (cdb_rob_idx == disp_rs2_tag);
        if (disp_rs1_hit_s) begin
            disp_rs1_val_s = cdb_data;
        end else begin
            disp_rs1_val_s = disp_rs1_data;
        end
        if (disp_rs2_hit_s) begin
            disp_rs2_val_s = cdb_data;
        end else begin
            disp_rs2_val_s = disp_rs2_data;
        end
    end

    // Handshake and occupancy bookkeeping. A slot freed by issue is only
    // counted from the next cycle, so a full station cannot accept a dispatch
    // in the same cycle as an issue.
    always_comb begin
        issue_fire_s = sel_found_s & iss_ready;
        disp_fire_s  = disp_valid & disp_ready & ~flush;
        valid_cnt_s  = count_ones(valid_r);
        keep_cnt_s   = valid_cnt_s - CNT_W'(issue_fire_s);
        free_next_s  = CNT_W'(DEPTH) - keep_cnt_s - CNT_W'(disp_fire_s);
        disp_age_s   = keep_cnt_s[IDX_W-1:0];
    end

    // Issue port: present the selected entry, zeros when nothing is ready
    always_comb begin
        if (sel_found_s) begin
            iss_valid    = 1'b1;
            iss_payload  = payload_r[sel_idx_s];
            iss_rob_idx  = rob_idx_r[sel_idx_s];
            iss_rs1_data = rs1_data_r[sel_idx_s];
            iss_rs2_data = rs2_data_r[sel_idx_s];
        end else begin
            iss_valid    = 1'b0;
            iss_payload  = '0;
            iss_rob_idx  = '0;
            iss_rs1_data = '0;
            iss_rs2_data = '0;
        end
    end

    assign free_count = free_count_r;
    assign disp_ready = (free_count_r != '0);

    // Entry state update: wakeup, age compaction, issue invalidate, dispatch write
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_r      <= '0;
            rs1_rdy_r    <= '0;
            rs2_rdy_r    <= '0;
            free_count_r <= CNT_W'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                payload_r[i]  <= '0;
                rob_idx_r[i]  <= '0;
                rs1_tag_r[i]  <= '0;
                rs1_data_r[i] <= '0;
                rs2_tag_r[i]  <= '0;
                rs2_data_r[i] <= '0;
                age_r[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i] && !rs1_rdy_r[i] && cdb_valid && (rs1_tag_r[i] == cdb_rob_idx)) begin
                    rs1_rdy_r[i]  <= 1'b1;
                    rs1_data_r[i] <= cdb_data;
                end
                if (valid_r[i] && !rs2_rdy_r[i] && cdb_valid && (rs2_tag_r[i] == cdb_rob_idx)) begin
                    rs2_rdy_r[i]  <= 1'b1;
                    rs2_data_r[i] <= cdb_data;
                end
                if (issue_fire_s && valid_r[i] && (age_r[i] > sel_age_s)) begin
                    age_r[i] <= age_r[i] - IDX_W'(1'b1);
                end
            end
            if (issue_fire_s) begin
                valid_r[sel_idx_s] <= 1'b0;
            end
            // The allocated slot is currently invalid, so it never collides
            // with the issue slot or with the wakeup/age updates above.
            if (disp_fire_s && free_found_s) begin
                valid_r[free_idx_s]    <= 1'b1;
                payload_r[free_idx_s]  <= disp_payload;
                rob_idx_r[free_idx_s]  <= disp_rob_idx;
                rs1_rdy_r[free_idx_s]  <= disp_rs1_ready | disp_rs1_hit_s;
                rs1_tag_r[free_idx_s]  <= disp_rs1_tag;
                rs1_data_r[free_idx_s] <= disp_rs1_val_s;
                rs2_rdy_r[free_idx_s]  <= disp_rs2_ready | disp_rs2_hit_s;
                rs2_tag_r[free_idx_s]  <= disp_rs2_tag;
                rs2_data_r[free_idx_s] <= disp_rs2_val_s;
                age_r[free_idx_s]      <= disp_age_s;
            end
            free_count_r <= free_next_s;
        end
    end

endmodule
